// File: rtl/smac_pkg.sv
// Shared types and width helpers for the bit-serial signed MAC engine.
// Zero-plane skipping is compiled in only when SMAC_ZERO_SKIP_EN is defined.
package smac_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WGT  = 3'd1,
      S_ACT  = 3'd2,
      S_ACC  = 3'd3,
      S_DONE = 3'd4
   } smac_state_t;

   function automatic int smac_rw(input int m, input int pa, input int pw);
      return $clog2(m) + pa + pw;
   endfunction

   // Width of a counter that must hold values 0..n.
   function automatic int smac_cw(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/smac_plane_popcnt.sv
// Combinational popcount of the lane-wise AND of one activation and one weight bit-plane.
module smac_plane_popcnt #(
   parameter int M = 16
) (
   input  logic [M-1:0]         act,
   input  logic [M-1:0]         wei,
   output logic [$clog2(M):0]   cnt
);

   localparam int CW = $clog2(M) + 1;

   // Sum of matching set bits across all lanes.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < M; i++) begin
         cnt = cnt + CW'(act[i] & wei[i]);
      end
   end

endmodule

// File: rtl/smac_seq_engine.sv
// Bit-serial signed dot-product engine: weight and activation bit-planes arrive MSB-first.
// Optional macro SMAC_ZERO_SKIP_EN bypasses the activation pass for all-zero weight planes.
module smac_seq_engine
   import smac_pkg::*;
#(
   parameter  int M  = 16,
   parameter  int Pa = 8,
   parameter  int Pw = 4,
   localparam int RW = smac_rw(M, Pa, Pw)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [M-1:0]  wei_plane,
   input  logic          wei_valid,
   output logic          wei_ready,
   input  logic [M-1:0]  act_plane,
   input  logic          act_valid,
   output logic          act_ready,
   output logic [RW-1:0] res_data,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          busy
);

   localparam int PCW = $clog2(M) + 1;
   localparam int A1W = $clog2(M) + Pa + 1;
   localparam int AW  = smac_cw(Pa);
   localparam int PW  = smac_cw(Pw);
   localparam logic [AW-1:0] ACNT_LAST = AW'(Pa - 1);
   localparam logic [PW-1:0] PCNT_LAST = PW'(Pw - 1);

   smac_state_t           state_r, state_nx;
   logic [M-1:0]          wplane_r, wplane_nx;
   logic signed [A1W-1:0] acc1_r, acc1_nx;
   logic signed [RW-1:0]  acc2_r, acc2_nx;
   logic [AW-1:0]         acnt_r, acnt_nx;
   logic [PW-1:0]         pcnt_r, pcnt_nx;

   logic [PCW-1:0]        pop_s;
   logic signed [A1W-1:0] pop_ext_s, term_s;
   logic signed [RW-1:0]  acc1_ext_s, acc2_term_s;
   logic                  wei_xfer_s, act_xfer_s;

   smac_plane_popcnt #(.M(M)) u_popcnt (
      .act (act_plane),
      .wei (wplane_r),
      .cnt (pop_s)
   );

   assign wei_xfer_s  = wei_valid & wei_ready;
   assign act_xfer_s  = act_valid & act_ready;
   // The first plane of each operand is the sign plane and is subtracted.
   assign pop_ext_s   = $signed(A1W'(pop_s));
   assign term_s      = (acnt_r == '0) ? -pop_ext_s : pop_ext_s;
   assign acc1_ext_s  = RW'(acc1_r);
   assign acc2_term_s = (pcnt_r == '0) ? -acc1_ext_s : acc1_ext_s;

   // Next-state and datapath update for the plane sequencer.
   always_comb begin
      state_nx  = state_r;
      wplane_nx = wplane_r;
      acc1_nx   = acc1_r;
      acc2_nx   = acc2_r;
      acnt_nx   = acnt_r;
      pcnt_nx   = pcnt_r;
      case (state_r)
         S_IDLE, S_WGT: begin
            if (wei_xfer_s) begin
               wplane_nx = wei_plane;
               acc1_nx   = '0;
               acnt_nx   = '0;
               if (state_r == S_IDLE) begin
                  acc2_nx = '0;
                  pcnt_nx = '0;
               end else begin
                  acc2_nx = acc2_r;
                  pcnt_nx = pcnt_r;
               end
`ifdef SMAC_ZERO_SKIP_EN
               if (wei_plane == '0) begin
                  state_nx = S_ACC;
               end else begin
                  state_nx = S_ACT;
               end
`else
               state_nx = S_ACT;
`endif
            end else begin
               state_nx = state_r;
            end
         end
         S_ACT: begin
            if (act_xfer_s) begin
               acc1_nx = (acc1_r <<< 1) + term_s;
               acnt_nx = acnt_r + AW'(1);
               if (acnt_r == ACNT_LAST) begin
                  state_nx = S_ACC;
               end else begin
                  state_nx = S_ACT;
               end
            end else begin
               state_nx = S_ACT;
            end
         end
         S_ACC: begin
            acc2_nx = (acc2_r <<< 1) + acc2_term_s;
            if (pcnt_r == PCNT_LAST) begin
               state_nx = S_DONE;
            end else begin
               pcnt_nx  = pcnt_r + PW'(1);
               state_nx = S_WGT;
            end
         end
         S_DONE: begin
            if (res_valid && res_ready) begin
               state_nx = S_IDLE;
            end else begin
               state_nx = S_DONE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake/result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= S_IDLE;
         wplane_r  <= '0;
         acc1_r    <= '0;
         acc2_r    <= '0;
         acnt_r    <= '0;
         pcnt_r    <= '0;
         wei_ready <= 1'b1;
         act_ready <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         busy      <= 1'b0;
      end else begin
         state_r   <= state_nx;
         wplane_r  <= wplane_nx;
         acc1_r    <= acc1_nx;
         acc2_r    <= acc2_nx;
         acnt_r    <= acnt_nx;
         pcnt_r    <= pcnt_nx;
         wei_ready <= (state_nx == S_IDLE) || (state_nx == S_WGT);
         act_ready <= (state_nx == S_ACT);
         res_valid <= (state_nx == S_DONE);
         res_data  <= (state_nx == S_DONE) ? acc2_nx : '0;
         busy      <= (state_nx != S_IDLE);
      end
   end

endmodule
